// File: rtl/display_decoder_pkg.sv
// display_pkg: shared constants, types and segment patterns for the decimal display decoder
package display_pkg;
    localparam int DIGITS = 6;
    localparam int CONV_BITS = 20;
    localparam logic [31:0] DISP_MAX = 32'd999999;
    typedef logic [3:0] seg_digit_t;
    typedef enum logic {IDLE, CONV} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [6:0] seg_pattern(input seg_digit_t d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/display_decoder_if.sv
// display_decoder_if: display value in, six active-low seven-segment digits and busy out
interface display_decoder_if;
    logic [31:0] value;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic busy;
    modport master (output value, input hex0, hex1, hex2, hex3, hex4, hex5, busy);
    modport slave (input value, output hex0, hex1, hex2, hex3, hex4, hex5, busy);
endinterface

// File: rtl/display_decoder_seg7_encode.sv
// seg7_encode: one BCD digit to an active-low {g,f,e,d,c,b,a} pattern, dash overriding blank
module seg7_encode
    import display_pkg::*;
(
    input  seg_digit_t digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);
    assign seg_o = dash_i ? SEG_DASH : blank_i ? SEG_BLANK : seg_pattern(digit_i);
endmodule

// File: rtl/display_decoder.sv
// display_decoder: sequential double-dabble of a 32-bit word onto six blanked seven-segment digits
module display_decoder
    import display_pkg::*;
(
    input logic clock,
    input logic reset,
    display_decoder_if.slave bus
);
    state_t state_q, state_d;
    logic [19:0] work_q, work_d;
    logic [23:0] bcd_q, bcd_d, dig_q, dig_d;
    logic [22:0] adj;
    logic [4:0] cnt_q, cnt_d;
    logic [31:0] shown_q, shown_d;
    logic ovf_q, ovf_d, ovf_shown_q, ovf_shown_d;
    logic [DIGITS-1:0] blank;
    logic [6:0] seg [DIGITS];

    // the top nibble's carry out falls outside six digits; overflow masks it anyway
    for (genvar k = 0; k < DIGITS - 1; k++) begin : g_adj
        assign adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
    assign adj[22:20] = bcd_q[23:20] >= 4'd5 ? 3'(bcd_q[23:20] + 4'd3) : bcd_q[22:20];

    always_comb begin
        state_d = state_q;
        work_d = work_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        shown_d = shown_q;
        ovf_d = ovf_q;
        ovf_shown_d = ovf_shown_q;
        dig_d = dig_q;
        if (state_q == IDLE) begin
            if (bus.value != shown_q) begin
                state_d = CONV;
                work_d = bus.value[19:0];
                shown_d = bus.value;
                bcd_d = '0;
                cnt_d = '0;
                ovf_d = bus.value > DISP_MAX;
            end
        end else begin
            bcd_d = {adj, work_q[19]};
            work_d = {work_q[18:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(CONV_BITS - 1)) begin
                state_d = IDLE;
                dig_d = bcd_d;
                ovf_shown_d = ovf_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            shown_q <= '0;
            ovf_q <= 1'b0;
            ovf_shown_q <= 1'b0;
            dig_q <= '0;
        end else begin
            state_q <= state_d;
            work_q <= work_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            shown_q <= shown_d;
            ovf_q <= ovf_d;
            ovf_shown_q <= ovf_shown_d;
            dig_q <= dig_d;
        end
    end

    // a digit blanks when it and every higher digit are zero; hex0 never blanks
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign blank[k] = (k > 0) && (dig_q[4*DIGITS-1:4*k] == '0);
        seg7_encode u_seg (
            .digit_i(dig_q[4*k +: 4]),
            .blank_i(blank[k]),
            .dash_i (ovf_shown_q),
            .seg_o  (seg[k])
        );
    end

    assign bus.hex0 = seg[0];
    assign bus.hex1 = seg[1];
    assign bus.hex2 = seg[2];
    assign bus.hex3 = seg[3];
    assign bus.hex4 = seg[4];
    assign bus.hex5 = seg[5];
    assign bus.busy = state_q == CONV;
endmodule

// File: tb/tb_display_decoder.sv
// tb_display_decoder: directed vectors for conversion, blanking, overflow, value tracking and reset abort
module tb_display_decoder;
    localparam logic [6:0] B = 7'b1111111;
    localparam logic [6:0] D = 7'b0111111;
    localparam logic [6:0] P [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    logic [41:0] hex_all;

    display_decoder_if bus ();

    display_decoder dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign hex_all = {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply(input logic [31:0] v, output int n);
        bus.value = v;
        @(negedge clk);
        wait_idle(n);
    endtask

    task automatic test_reset;
        bus.value = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (hex_all !== {B, B, B, B, B, P[0]}) begin
            fails++;
            $display("FAIL reset_hex: got %h want %h", hex_all, {B, B, B, B, B, P[0]});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy cycle %0d: got %b want 0", i, bus.busy);
            end
        end
        checks++;
        if (hex_all !== {B, B, B, B, B, P[0]}) begin
            fails++;
            $display("FAIL reset_hold_hex: got %h want %h", hex_all, {B, B, B, B, B, P[0]});
        end
    endtask

    task automatic test_convert;
        int n;
        apply(32'd123456, n);
        checks++;
        if (n != 20) begin
            fails++;
            $display("FAIL convert_busy_len: got %0d want 20", n);
        end
        checks++;
        if (hex_all !== {P[1], P[2], P[3], P[4], P[5], P[6]}) begin
            fails++;
            $display("FAIL convert_123456: got %h want %h", hex_all, {P[1], P[2], P[3], P[4], P[5], P[6]});
        end
    endtask

    task automatic test_blank_overflow;
        int n;
        apply(32'd7, n);
        checks++;
        if (n != 20 || hex_all !== {B, B, B, B, B, P[7]}) begin
            fails++;
            $display("FAIL blank_7: got len %0d hex %h want len 20 hex %h", n, hex_all, {B, B, B, B, B, P[7]});
        end
        apply(32'd1000000, n);
        checks++;
        if (n != 20 || hex_all !== {D, D, D, D, D, D}) begin
            fails++;
            $display("FAIL ovf_1000000: got len %0d hex %h want len 20 hex %h", n, hex_all, {D, D, D, D, D, D});
        end
        apply(32'hFFFF_FFFF, n);
        checks++;
        if (n != 20 || hex_all !== {D, D, D, D, D, D}) begin
            fails++;
            $display("FAIL ovf_ffffffff: got len %0d hex %h want len 20 hex %h", n, hex_all, {D, D, D, D, D, D});
        end
        apply(32'd999999, n);
        checks++;
        if (n != 20 || hex_all !== {P[9], P[9], P[9], P[9], P[9], P[9]}) begin
            fails++;
            $display("FAIL max_999999: got len %0d hex %h want len 20 hex %h", n, hex_all, {P[9], P[9], P[9], P[9], P[9], P[9]});
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus.value = 32'd5;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_start_busy: got %b want 1", bus.busy);
        end
        bus.value = 32'd42;
        @(negedge clk);
        bus.value = 32'd99;
        repeat (18) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || hex_all !== {P[9], P[9], P[9], P[9], P[9], P[9]}) begin
            fails++;
            $display("FAIL b2b_e19: got busy %b hex %h want busy 1 hex %h", bus.busy, hex_all, {P[9], P[9], P[9], P[9], P[9], P[9]});
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || hex_all !== {B, B, B, B, B, P[5]}) begin
            fails++;
            $display("FAIL b2b_first_5: got busy %b hex %h want busy 0 hex %h", bus.busy, hex_all, {B, B, B, B, B, P[5]});
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_start: got %b want 1", bus.busy);
        end
        wait_idle(n);
        checks++;
        if (n != 20 || hex_all !== {B, B, B, B, P[9], P[9]}) begin
            fails++;
            $display("FAIL b2b_second_99: got len %0d hex %h want len 20 hex %h", n, hex_all, {B, B, B, B, P[9], P[9]});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || hex_all !== {B, B, B, B, P[9], P[9]}) begin
            fails++;
            $display("FAIL b2b_settled: got busy %b hex %h want busy 0 hex %h", bus.busy, hex_all, {B, B, B, B, P[9], P[9]});
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bus.value = 32'd888888;
        repeat (11) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy_before_reset: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || hex_all !== {B, B, B, B, B, P[0]}) begin
            fails++;
            $display("FAIL mid_reset_state: got busy %b hex %h want busy 0 hex %h", bus.busy, hex_all, {B, B, B, B, B, P[0]});
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_restart: got %b want 1", bus.busy);
        end
        wait_idle(n);
        checks++;
        if (n != 20 || hex_all !== {P[8], P[8], P[8], P[8], P[8], P[8]}) begin
            fails++;
            $display("FAIL mid_888888: got len %0d hex %h want len 20 hex %h", n, hex_all, {P[8], P[8], P[8], P[8], P[8], P[8]});
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blank_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
